hazard_control_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 23 ++
 rtl/forward_select.sv | 30 +++
 rtl/hazard_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } hazard_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Register 0 can be hard-wired to zero, in which case it never carries a dependency.
    function automatic logic adr_match(input logic [2:0] a, input logic [2:0] b,
                                       input logic r0_is_zero);
        return (a == b) && !(r0_is_zero && (a == 3'd0));
    endfunction

endpackage

// File: rtl/forward_select.sv
// E-stage operand bypass select for one source operand; M result wins over W.
module forward_select
    import hazard_pkg::*;
#(
    parameter int unsigned R0_IS_ZERO = 32'd0
) (
    input  logic [2:0] src_e,
    input  logic       reg_write_m,
    input  logic       mem_to_reg_m,
    input  logic [2:0] reg_write_adr_m,
    input  logic       reg_write_w,
    input  logic [2:0] reg_write_adr_w,
    output logic [1:0] fwd_sel
);

    localparam logic R0_ZERO = (R0_IS_ZERO != 32'd0);

    // A load in M has no data yet, so only ALU results are bypassed from M.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && !mem_to_reg_m && adr_match(reg_write_adr_m, src_e, R0_ZERO)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_w && adr_match(reg_write_adr_w, src_e, R0_ZERO)) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencing for load-use and taken-branch hazards plus E-stage forwarding.
// Optional HAZARD_STATS_EN adds saturating stall_cycles/flush_cycles counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_LATENCY   = 32'd1,
    parameter int unsigned BRANCH_PENALTY = 32'd1,
    parameter int unsigned R0_IS_ZERO     = 32'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] reg_read_adr1_d,
    input  logic [2:0] reg_read_adr2_d,
    input  logic       use_adr2_d,
    input  logic [2:0] reg_read_adr1_e,
    input  logic [2:0] reg_read_adr2_e,
    input  logic       reg_write_e,
    input  logic [2:0] reg_write_adr_e,
    input  logic       mem_to_reg_e,
    input  logic       reg_write_m,
    input  logic [2:0] reg_write_adr_m,
    input  logic       mem_to_reg_m,
    input  logic       reg_write_w,
    input  logic [2:0] reg_write_adr_w,
    input  logic       branch_taken_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles
`endif
);

    localparam logic R0_ZERO = (R0_IS_ZERO != 32'd0);
    localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LOAD_LATENCY - 32'd1);
    localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'(BRANCH_PENALTY - 32'd1);

    hazard_state_e    state_r;
    hazard_state_e    state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             lu_hit_s;
    logic             stall_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    forward_select #(.R0_IS_ZERO(R0_IS_ZERO)) u_fwd_a (
        .src_e           (reg_read_adr1_e),
        .reg_write_m     (reg_write_m),
        .mem_to_reg_m    (mem_to_reg_m),
        .reg_write_adr_m (reg_write_adr_m),
        .reg_write_w     (reg_write_w),
        .reg_write_adr_w (reg_write_adr_w),
        .fwd_sel         (fwd_a_s)
    );

    forward_select #(.R0_IS_ZERO(R0_IS_ZERO)) u_fwd_b (
        .src_e           (reg_read_adr2_e),
        .reg_write_m     (reg_write_m),
        .mem_to_reg_m    (mem_to_reg_m),
        .reg_write_adr_m (reg_write_adr_m),
        .reg_write_w     (reg_write_w),
        .reg_write_adr_w (reg_write_adr_w),
        .fwd_sel         (fwd_b_s)
    );

    // Load in E whose destination feeds the instruction waiting in D.
    always_comb begin
        lu_hit_s = 1'b0;
        if (reg_write_e && mem_to_reg_e) begin
            lu_hit_s = adr_match(reg_write_adr_e, reg_read_adr1_d, R0_ZERO) ||
                       (use_adr2_d && adr_match(reg_write_adr_e, reg_read_adr2_d, R0_ZERO));
        end else begin
            lu_hit_s = 1'b0;
        end
    end

    // State and countdown register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next state and raw stall/flush controls; a taken branch outranks a load-use hit
    // because the D instruction is on the wrong path.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        stall_s      = 1'b0;
        flush_d_s    = 1'b0;
        flush_e_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (branch_taken_e) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (BRANCH_PENALTY > 32'd1) begin
                        state_next_s = BR_FLUSH;
                        cnt_next_s   = BR_LOAD;
                    end else begin
                        state_next_s = RUN;
                    end
                end else if (lu_hit_s) begin
                    stall_s   = 1'b1;
                    flush_e_s = 1'b1;
                    if (LOAD_LATENCY > 32'd1) begin
                        state_next_s = LU_STALL;
                        cnt_next_s   = LU_LOAD;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            LU_STALL: begin
                stall_s    = 1'b1;
                flush_e_s  = 1'b1;
                cnt_next_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = LU_STALL;
                end
            end
            BR_FLUSH: begin
                flush_d_s  = 1'b1;
                cnt_next_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = BR_FLUSH;
                end
            end
            default: begin
                state_next_s = RUN;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Reset forces a bubble into both pipeline registers and disables bypassing.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b1;
        flush_e     = 1'b1;
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        if (reset) begin
            stall_f     = 1'b0;
            stall_d     = 1'b0;
            flush_d     = 1'b1;
            flush_e     = 1'b1;
            forward_a_e = FWD_RF;
            forward_b_e = FWD_RF;
        end else begin
            stall_f     = stall_s;
            stall_d     = stall_s;
            flush_d     = flush_d_s;
            flush_e     = flush_e_s;
            forward_a_e = fwd_a_s;
            forward_b_e = fwd_b_s;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles_r;
    logic [15:0] flush_cycles_r;

    // Saturating event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_r <= 16'h0000;
            flush_cycles_r <= 16'h0000;
        end else begin
            if (stall_d && (stall_cycles_r != 16'hFFFF)) begin
                stall_cycles_r <= stall_cycles_r + 16'd1;
            end
            if (flush_d && (flush_cycles_r != 16'hFFFF)) begin
                flush_cycles_r <= flush_cycles_r + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_cycles = flush_cycles_r;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: two instances (LL=1/BP=2/R0=0 and LL=3/BP=1/R0=1) share one stimulus.
module tb_hazard_control_unit;

    logic       clock;
    logic       reset;
    logic [2:0] reg_read_adr1_d, reg_read_adr2_d, reg_read_adr1_e, reg_read_adr2_e;
    logic       use_adr2_d;
    logic       reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, reg_write_w;
    logic [2:0] reg_write_adr_e, reg_write_adr_m, reg_write_adr_w;
    logic       branch_taken_e;

    logic       stall_f_1, stall_d_1, flush_d_1, flush_e_1;
    logic       stall_f_3, stall_d_3, flush_d_3, flush_e_3;
    logic [1:0] fwd_a_1, fwd_b_1, fwd_a_3, fwd_b_3;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles_1, flush_cycles_1, stall_cycles_3, flush_cycles_3;
`endif

    int n_compared;
    int n_mismatched;

    hazard_control_unit #(.LOAD_LATENCY(1), .BRANCH_PENALTY(2), .R0_IS_ZERO(0)) u_dut_1 (
        .clock(clock), .reset(reset),
        .reg_read_adr1_d(reg_read_adr1_d), .reg_read_adr2_d(reg_read_adr2_d),
        .use_adr2_d(use_adr2_d),
        .reg_read_adr1_e(reg_read_adr1_e), .reg_read_adr2_e(reg_read_adr2_e),
        .reg_write_e(reg_write_e), .reg_write_adr_e(reg_write_adr_e),
        .mem_to_reg_e(mem_to_reg_e),
        .reg_write_m(reg_write_m), .reg_write_adr_m(reg_write_adr_m),
        .mem_to_reg_m(mem_to_reg_m),
        .reg_write_w(reg_write_w), .reg_write_adr_w(reg_write_adr_w),
        .branch_taken_e(branch_taken_e),
        .stall_f(stall_f_1), .stall_d(stall_d_1), .flush_d(flush_d_1), .flush_e(flush_e_1),
        .forward_a_e(fwd_a_1), .forward_b_e(fwd_b_1)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles_1), .flush_cycles(flush_cycles_1)
`endif
    );

    hazard_control_unit #(.LOAD_LATENCY(3), .BRANCH_PENALTY(1), .R0_IS_ZERO(1)) u_dut_3 (
        .clock(clock), .reset(reset),
        .reg_read_adr1_d(reg_read_adr1_d), .reg_read_adr2_d(reg_read_adr2_d),
        .use_adr2_d(use_adr2_d),
        .reg_read_adr1_e(reg_read_adr1_e), .reg_read_adr2_e(reg_read_adr2_e),
        .reg_write_e(reg_write_e), .reg_write_adr_e(reg_write_adr_e),
        .mem_to_reg_e(mem_to_reg_e),
        .reg_write_m(reg_write_m), .reg_write_adr_m(reg_write_adr_m),
        .mem_to_reg_m(mem_to_reg_m),
        .reg_write_w(reg_write_w), .reg_write_adr_w(reg_write_adr_w),
        .branch_taken_e(branch_taken_e),
        .stall_f(stall_f_3), .stall_d(stall_d_3), .flush_d(flush_d_3), .flush_e(flush_e_3),
        .forward_a_e(fwd_a_3), .forward_b_e(fwd_b_3)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles_3), .flush_cycles(flush_cycles_3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Control bundles ordered {stall_f, stall_d, flush_d, flush_e}.
    logic [3:0] ctl_1, ctl_3;
    assign ctl_1 = {stall_f_1, stall_d_1, flush_d_1, flush_e_1};
    assign ctl_3 = {stall_f_3, stall_d_3, flush_d_3, flush_e_3};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        reg_read_adr1_d = 3'd0; reg_read_adr2_d = 3'd0; use_adr2_d = 1'b0;
        reg_read_adr1_e = 3'd0; reg_read_adr2_e = 3'd0;
        reg_write_e = 1'b0; reg_write_adr_e = 3'd0; mem_to_reg_e = 1'b0;
        reg_write_m = 1'b0; reg_write_adr_m = 3'd0; mem_to_reg_m = 1'b0;
        reg_write_w = 1'b0; reg_write_adr_w = 3'd0;
        branch_taken_e = 1'b0;
    endtask

    task automatic set_lu_hit(input logic [2:0] adr);
        reg_write_e = 1'b1; mem_to_reg_e = 1'b1; reg_write_adr_e = adr; reg_read_adr1_d = adr;
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        clear_inputs();
        reset = 1'b1;
        // Bypass condition present during reset must be masked.
        reg_write_m = 1'b1; reg_write_adr_m = 3'd5; reg_read_adr1_e = 3'd5;
        tick();
        tick();
        check("rst_ctl_1", {12'd0, ctl_1}, 16'h0003);
        check("rst_ctl_3", {12'd0, ctl_3}, 16'h0003);
        check("rst_fwd_a", {14'd0, fwd_a_1}, 16'h0000);

        reset = 1'b0;
        clear_inputs();
        #1;
        check("idle_ctl_1", {12'd0, ctl_1}, 16'h0000);
        check("idle_ctl_3", {12'd0, ctl_3}, 16'h0000);
`ifdef HAZARD_STATS_EN
        check("stats_rst_stall", stall_cycles_1, 16'h0000);
        check("stats_rst_flush", flush_cycles_1, 16'h0000);
`endif

        // Load-use hit on source 2 only counts when D actually reads it.
        reg_write_e = 1'b1; mem_to_reg_e = 1'b1; reg_write_adr_e = 3'd3;
        reg_read_adr1_d = 3'd1; reg_read_adr2_d = 3'd3; use_adr2_d = 1'b0;
        #1;
        check("src2_unused", {12'd0, ctl_1}, 16'h0000);
        use_adr2_d = 1'b1;
        #1;
        check("src2_used", {12'd0, ctl_1}, 16'h000D);
        mem_to_reg_e = 1'b0;
        #1;
        check("not_load", {12'd0, ctl_1}, 16'h0000);
        clear_inputs();
        #1;

        // Load-use: LL=1 stalls one cycle; LL=3 stalls three. Branch in LU_STALL is ignored.
        set_lu_hit(3'd3);
        #1;
        check("lu_c1_1", {12'd0, ctl_1}, 16'h000D);
        check("lu_c1_3", {12'd0, ctl_3}, 16'h000D);
        tick();
        clear_inputs();
        branch_taken_e = 1'b1;
        #1;
        check("lu_c2_1_br", {12'd0, ctl_1}, 16'h0003);
        check("lu_c2_3", {12'd0, ctl_3}, 16'h000D);
        tick();
        clear_inputs();
        #1;
        check("br_flush_1", {12'd0, ctl_1}, 16'h0002);
        check("lu_c3_3", {12'd0, ctl_3}, 16'h000D);
        tick();
        check("lu_c4_1", {12'd0, ctl_1}, 16'h0000);
        check("lu_c4_3", {12'd0, ctl_3}, 16'h0000);

        // Taken branch with simultaneous load-use hit: branch wins.
        set_lu_hit(3'd4);
        branch_taken_e = 1'b1;
        #1;
        check("br_c1_1", {12'd0, ctl_1}, 16'h0003);
        check("br_c1_3", {12'd0, ctl_3}, 16'h0003);
        tick();
        clear_inputs();
        #1;
        check("br_c2_1", {12'd0, ctl_1}, 16'h0002);
        check("br_c2_3", {12'd0, ctl_3}, 16'h0000);
        tick();
        check("br_c3_1", {12'd0, ctl_1}, 16'h0000);

        // Forwarding priority M over W; a load in M is not bypassed.
        reg_write_m = 1'b1; reg_write_adr_m = 3'd5;
        reg_write_w = 1'b1; reg_write_adr_w = 3'd5;
        reg_read_adr1_e = 3'd5; reg_read_adr2_e = 3'd2;
        #1;
        check("fwd_a_m", {14'd0, fwd_a_1}, 16'h0002);
        check("fwd_b_none", {14'd0, fwd_b_1}, 16'h0000);
        reg_read_adr2_e = 3'd5;
        #1;
        check("fwd_b_m", {14'd0, fwd_b_1}, 16'h0002);
        reg_write_m = 1'b0;
        #1;
        check("fwd_a_w", {14'd0, fwd_a_1}, 16'h0001);
        reg_write_m = 1'b1; reg_write_adr_m = 3'd2;
        #1;
        check("fwd_a_w_m_miss", {14'd0, fwd_a_1}, 16'h0001);
        reg_write_adr_m = 3'd5; mem_to_reg_m = 1'b1; reg_write_w = 1'b0;
        #1;
        check("fwd_a_load_m", {14'd0, fwd_a_1}, 16'h0000);
        clear_inputs();
        #1;

        // Register 0 never matches when R0_IS_ZERO is set.
        set_lu_hit(3'd0);
        reg_write_m = 1'b1; reg_write_adr_m = 3'd0; reg_read_adr1_e = 3'd0;
        #1;
        check("r0_ctl_3", {12'd0, ctl_3}, 16'h0000);
        check("r0_fwd_3", {14'd0, fwd_a_3}, 16'h0000);
        check("r0_ctl_1", {12'd0, ctl_1}, 16'h000D);
        check("r0_fwd_1", {14'd0, fwd_a_1}, 16'h0002);
        clear_inputs();
        #1;

        // Reset during the second LU_STALL cycle aborts the sequence.
        set_lu_hit(3'd6);
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        check("rst_mid_3", {12'd0, ctl_3}, 16'h0003);
        check("rst_mid_1", {12'd0, ctl_1}, 16'h0003);
        tick();
        check("rst_hold_3", {12'd0, ctl_3}, 16'h0003);
        reset = 1'b0;
        #1;
        check("post_rst_3", {12'd0, ctl_3}, 16'h0000);
`ifdef HAZARD_STATS_EN
        check("stats_post_stall", stall_cycles_3, 16'h0000);
        check("stats_post_flush", flush_cycles_3, 16'h0000);
`endif
        tick();
        check("post_rst2_3", {12'd0, ctl_3}, 16'h0000);
`ifdef HAZARD_STATS_EN
        set_lu_hit(3'd2);
        tick();
        clear_inputs();
        #1;
        check("stats_one_stall", stall_cycles_1, 16'h0001);
        check("stats_no_flush", flush_cycles_1, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
